// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi BER checker.
//   state_e   : checker alignment state (skip warm-up, search, locked)
//   sat_inc() : increment that sticks at the all-ones value of a w-bit field
//   CNT_W_DEF : default statistic counter width
package viterbi_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Saturating increment of a w-bit value carried in 32 bits (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bit_fifo.sv
// 1-bit-wide synchronous FIFO holding the uncoded source bits.
//   clk, rst      : clock, asynchronous active-low reset
//   clear_i       : synchronous flush (wins over push/pop)
//   push_i, bit_i : write strobe and data; caller guarantees room
//   pop_i         : drop the head entry
//   pop2_i        : with pop_i, drop the head and the entry behind it (slip)
//   head_o        : current head bit (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy status
// Pointers wrap by natural overflow, so DEPTH must be a power of 2.
module bit_fifo #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          bit_i,
  input  logic          pop_i,
  input  logic          pop2_i,
  output logic          head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic [1:0]       npop;

  assign npop = pop_i ? (pop2_i ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= bit_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      rd_q    <= rd_q + AW'(npop);
      count_q <= count_q + CW'(push_i) - CW'(npop);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for the rate-1/2 encoder / Viterbi decoder loop.
// Source bits are queued as they enter the encoder; decoder output bits are
// aligned against them (skip warm-up, slip-search, lock) and then compared.
//   clk, rst                 : clock, asynchronous active-low reset
//   clear_i                  : synchronous flush of FIFO, counters and flags
//   src_valid_i, src_bit_i   : encoder input strobe and bit
//   dec_valid_i, dec_bit_i   : decoder output strobe and bit
//   locked_o                 : alignment achieved
//   bit_ct_o, err_ct_o       : bits compared / mismatches while locked
//   burst_ct_o, max_burst_o  : number of error runs / longest run
//   overflow_o, underflow_o  : sticky FIFO drop / empty-read flags
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int SKIP     = 0,
  parameter int SYNC_LEN = 16,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             src_valid_i,
  input  logic             src_bit_i,
  input  logic             dec_valid_i,
  input  logic             dec_bit_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] bit_ct_o,
  output logic [CNT_W-1:0] err_ct_o,
  output logic [CNT_W-1:0] burst_ct_o,
  output logic [CNT_W-1:0] max_burst_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int SKW = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
  // With no warm-up bits to discard the checker starts directly in SEARCH.
  localparam state_e ST_INIT = (SKIP == 0) ? ST_SEARCH : ST_SKIP;

  state_e           state_q;
  logic [SKW-1:0]   skip_ct_q;
  logic [7:0]       match_ct_q;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] bit_ct_q, err_ct_q, burst_ct_q, max_burst_q;
  logic             locked_q, overflow_q, underflow_q;

  logic             fifo_head, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             consume, pop, pop2, push, mismatch;
  logic [CNT_W-1:0] run_nx;

  // A decoder bit is only acted on when there is a source bit to pair with.
  assign consume  = dec_valid_i && !fifo_empty && !clear_i;
  assign pop      = consume && (state_q != ST_SKIP);
  assign mismatch = (fifo_head != dec_bit_i);
  // Slip only if something remains behind the head after the first pop.
  assign pop2     = pop && (state_q == ST_SEARCH) && mismatch && (fifo_count >= CW'(2));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = src_valid_i && !clear_i && (!fifo_full || pop);
  assign run_nx   = CNT_W'(sat_inc(32'(run_q), CNT_W));

  bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .push_i  (push),
    .bit_i   (src_bit_i),
    .pop_i   (pop),
    .pop2_i  (pop2),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      skip_ct_q   <= '0;
      match_ct_q  <= '0;
      run_q       <= '0;
      bit_ct_q    <= '0;
      err_ct_q    <= '0;
      burst_ct_q  <= '0;
      max_burst_q <= '0;
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= ST_INIT;
      skip_ct_q   <= '0;
      match_ct_q  <= '0;
      run_q       <= '0;
      bit_ct_q    <= '0;
      err_ct_q    <= '0;
      burst_ct_q  <= '0;
      max_burst_q <= '0;
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (src_valid_i && fifo_full && !pop) overflow_q <= 1'b1;
      if (dec_valid_i && fifo_empty)        underflow_q <= 1'b1;
      if (consume) begin
        case (state_q)
          ST_SKIP: begin
            skip_ct_q <= skip_ct_q + SKW'(1);
            if (int'(skip_ct_q) + 1 >= SKIP) state_q <= ST_SEARCH;
          end
          ST_SEARCH: begin
            if (!mismatch) begin
              match_ct_q <= match_ct_q + 8'd1;
              if (int'(match_ct_q) + 1 >= SYNC_LEN) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              match_ct_q <= '0;
            end
          end
          ST_LOCKED: begin
            bit_ct_q <= CNT_W'(sat_inc(32'(bit_ct_q), CNT_W));
            if (mismatch) begin
              err_ct_q <= CNT_W'(sat_inc(32'(err_ct_q), CNT_W));
              // A new run starts when the previous locked compare matched.
              if (run_q == '0) burst_ct_q <= CNT_W'(sat_inc(32'(burst_ct_q), CNT_W));
              run_q <= run_nx;
              if (run_nx > max_burst_q) max_burst_q <= run_nx;
            end else begin
              run_q <= '0;
            end
          end
          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

  assign locked_o    = locked_q;
  assign bit_ct_o    = bit_ct_q;
  assign err_ct_o    = err_ct_q;
  assign burst_ct_o  = burst_ct_q;
  assign max_burst_o = max_burst_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-end bit-error-rate checker for the rate-1/2 convolutional encoder / Viterbi decoder loop. It buffers the uncoded source bits presented to the encoder and aligns them to the decoder output stream. It then compares the two bit by bit and reports total bits, bit errors, error-burst count and longest burst. It sits beside the decoder in the tx/rx top and replaces simulation-only `$display` error accounting with synthesizable counters.

## Interface
- DEPTH, 64: source-bit FIFO depth (power of 2, ≥ 4).
- SKIP, 0: number of leading decoder output bits discarded after reset/clear (traceback warm-up).
- SYNC_LEN, 16: consecutive matches required to declare lock (1..255).
- CNT_W, 16: width of all statistic counters.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear: flush FIFO, zero counters and flags, state -> SKIP.
- src_valid_i  in  1  source bit strobe (same strobe as encoder enable).
- src_bit_i  in  1  uncoded source bit.
- dec_valid_i  in  1  decoder output strobe.
- dec_bit_i  in  1  decoded bit.
- locked_o  out  1  alignment achieved.
- bit_ct_o  out  CNT_W  bits compared while locked.
- err_ct_o  out  CNT_W  mismatches while locked.
- burst_ct_o  out  CNT_W  number of error runs (run = ≥1 consecutive mismatches).
- max_burst_o  out  CNT_W  longest run length seen.
- overflow_o  out  1  sticky: source bit dropped on full FIFO.
- underflow_o  out  1  sticky: decoder bit arrived with FIFO empty.

## Operation
- Reset values: all outputs 0; FIFO empty; state SKIP (IDLE if SKIP=0 goes straight to SEARCH on first cycle); skip/match/run counters 0.
- FIFO push: src_valid_i and (not full or a pop happens the same cycle). Push while full without pop: bit dropped, overflow_o <= 1.
- Decoder bit consumed only when dec_valid_i; FIFO empty at that time: bit ignored, underflow_o <= 1, no state change.
- States:
  - SKIP: each dec bit discarded (no pop); after SKIP bits -> SEARCH.
  - SEARCH: compare dec_bit_i with FIFO head, pop head. Match: match_ct++; reaching SYNC_LEN -> LOCKED, locked_o <= 1. Mismatch: match_ct <= 0 and one additional head entry is popped (slip) if FIFO still non-empty after the first pop; otherwise no slip.
  - LOCKED: compare, pop; bit_ct++; mismatch: err_ct++, run_len++; if previous compare matched (or first locked compare), burst_ct++. Match: run_len <= 0. max_burst <= max(max_burst, run_len+1) on every mismatch. Stays LOCKED until clear_i or rst.
- Matches during SEARCH are not counted in bit_ct_o.
- All statistic counters saturate at all-ones; run_len saturates likewise.
- clear_i has priority over simultaneous push/pop; the push in that cycle is dropped without setting overflow_o.
- Reset mid-stream: immediate return to reset values, no partial counts retained.

## Timing
- Single-cycle pipeline: stats/flags reflect a dec_valid_i sample on the following rising edge.
- locked_o rises the cycle after the SYNC_LEN-th consecutive match.
- Source bit pushed at edge n is comparable by a dec_valid_i at edge n+1 or later (no same-cycle bypass of empty FIFO).
- Push and pop in the same cycle permitted at any occupancy; occupancy unchanged (slip cycles: net −1).
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package viterbi_pkg: state enum (SKIP, SEARCH, LOCKED), a saturating-increment function, and the default CNT_W constant.
- Sub-module bit_fifo: 1-bit-wide synchronous FIFO with push, pop, pop2 (slip), full, empty, count; pointer wrap by DEPTH power-of-2 masking.
- Top-level viterbi_ber_checker holds the FSM and the counters.

## Test plan
- Error-free loop, SKIP=0, decoder latency 0, 300 random bits -> locked_o after 16 compares, bit_ct_o=284, err_ct_o=0, burst_ct_o=0.
- Decoder stream offset by 3 dropped leading bits -> 3 slips in SEARCH, then lock; remaining compares error-free.
- Locked, inject flips at bit positions 50, 51, 52 and 100 -> err_ct_o=4, burst_ct_o=2, max_burst_o=3.
- 70 source pushes with no decoder pops, DEPTH=64 -> overflow_o=1 at 65th push, FIFO count stays 64; dec_valid_i on empty FIFO -> underflow_o=1.
- CNT_W=4, 20 locked errors -> err_ct_o saturates at 15; clear_i mid-stream -> all outputs 0 next cycle, state SKIP.
- rst asserted during LOCKED with a push in flight -> outputs 0 immediately (asynchronous), FIFO empty after release.
